// File: rtl/click_pkg.sv
// rtl/click_pkg.sv - shared types for the click decoder
package click_pkg;

  typedef enum logic {
    IDLE        = 1'b0,
    WAIT_SECOND = 1'b1
  } click_state_t;

endpackage

// File: rtl/pb_edge_sync.sv
// rtl/pb_edge_sync.sv - two-flop synchroniser plus history flop, emits one rise per press
module pb_edge_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pb_i,
  output logic rise_o
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= pb_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise_o = s2_q & ~s3_q;

endmodule

// File: rtl/click_decoder.sv
// rtl/click_decoder.sv - single/double click classifier with press counter
// Optional CLICK_SATURATE_EN: press_count saturates instead of wrapping.
module click_decoder
  import click_pkg::*;
#(
  parameter int WINDOW_CYCLES = 25_000_000,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pb_in,
  output logic             single_click,
  output logic             double_click,
  output logic             busy,
  output logic [CNT_W-1:0] press_count
);

  localparam int TW = $clog2(WINDOW_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(WINDOW_CYCLES - 1);

  logic             rise;
  click_state_t     state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             single_q, single_d;
  logic             double_q, double_d;
  logic [CNT_W-1:0] count_q, count_d;

  pb_edge_sync u_sync (
    .clk_i  (clk),
    .rst_i  (rst),
    .pb_i   (pb_in),
    .rise_o (rise)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      single_q <= 1'b0;
      double_q <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      single_q <= single_d;
      double_q <= double_d;
      count_q  <= count_d;
    end
  end

  // A rise arriving on the timeout cycle is checked first, so it wins.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    single_d = 1'b0;
    double_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = WAIT_SECOND;
          timer_d = '0;
        end
      end
      WAIT_SECOND: begin
        if (rise) begin
          double_d = 1'b1;
          state_d  = IDLE;
        end else if (timer_q == TIMER_LAST) begin
          single_d = 1'b1;
          state_d  = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
`ifdef CLICK_SATURATE_EN
    if (rise && (count_q != {CNT_W{1'b1}})) count_d = count_q + CNT_W'(1);
`else
    if (rise) count_d = count_q + CNT_W'(1);
`endif
  end

  assign single_click = single_q;
  assign double_click = double_q;
  assign busy         = (state_q == WAIT_SECOND);
  assign press_count  = count_q;

endmodule
